// File: rtl/mdu_hilo_pkg.sv
// Shared op codes, FSM state encodings and decode helpers for the HI/LO multiply/divide unit.
package mdu_hilo_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_e;

   // MULT/MULTU/DIV/DIVU occupy the lower half of the op space.
   function automatic logic op_is_arith(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

   // Even arithmetic codes are the signed variants.
   function automatic logic op_is_signed(input logic [2:0] op);
      return (op[0] == 1'b0);
   endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: per-lane for operand magnitudes,
// or across the joined {hi,lo} pair for a full-width product.
module mdu_sign_fix
   import mdu_hilo_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] in_hi,
   input  logic [WIDTH-1:0] in_lo,
   input  logic             neg_hi,
   input  logic             neg_lo,
   input  logic             joined,
   output logic [WIDTH-1:0] out_hi,
   output logic [WIDTH-1:0] out_lo
);

   logic [2*WIDTH-1:0] wide_neg;

   always_comb begin
      wide_neg = -{in_hi, in_lo};
      if (joined) begin
         {out_hi, out_lo} = neg_hi ? wide_neg : {in_hi, in_lo};
      end else begin
         out_hi = neg_hi ? -in_hi : in_hi;
         out_lo = neg_lo ? -in_lo : in_lo;
      end
   end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with HI/LO registers; one shift-add or
// restoring shift-subtract step per RUN cycle, sign correction in FIX.
module mdu_hilo
   import mdu_hilo_pkg::*;
#(
   parameter int               WIDTH   = 32,
   parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic             busy,
   output logic             done,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   mdu_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] mag_q, mag_d;
   logic             is_mul_q, is_mul_d;
   logic             div0_q, div0_d;
   logic             neg_hi_q, neg_hi_d;
   logic             neg_lo_q, neg_lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             rs_neg, rt_neg;
   logic [WIDTH-1:0] abs_rs, abs_rt;
   logic [WIDTH-1:0] res_hi, res_lo;
   logic [WIDTH-1:0] mul_addend;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;

   assign rs_neg = op_is_signed(op) & rs_val[WIDTH-1];
   assign rt_neg = op_is_signed(op) & rt_val[WIDTH-1];

   mdu_sign_fix #(.WIDTH(WIDTH)) u_opnd_fix (
      .in_hi  (rs_val),
      .in_lo  (rt_val),
      .neg_hi (rs_neg),
      .neg_lo (rt_neg),
      .joined (1'b0),
      .out_hi (abs_rs),
      .out_lo (abs_rt)
   );

   mdu_sign_fix #(.WIDTH(WIDTH)) u_res_fix (
      .in_hi  (acc_q[WIDTH-1:0]),
      .in_lo  (q_q),
      .neg_hi (neg_hi_q),
      .neg_lo (neg_lo_q),
      .joined (is_mul_q),
      .out_hi (res_hi),
      .out_lo (res_lo)
   );

   // Multiply: q holds the multiplier, mag the multiplicand; product shifts right into q.
   // Divide: q holds the dividend/quotient, mag the divisor; acc is the partial remainder.
   assign mul_addend = q_q[0] ? mag_q : '0;
   assign mul_sum    = acc_q + {1'b0, mul_addend};
   assign div_shift  = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
   assign div_diff   = div_shift - {1'b0, mag_q};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      q_d      = q_q;
      mag_d    = mag_q;
      is_mul_d = is_mul_q;
      div0_d   = div0_q;
      neg_hi_d = neg_hi_q;
      neg_lo_d = neg_lo_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (start && op_is_arith(op)) begin
               state_d  = ST_RUN;
               cnt_d    = CW'(WIDTH-1);
               acc_d    = '0;
               is_mul_d = ~op[1];
               q_d      = op[1] ? abs_rs : abs_rt;
               mag_d    = op[1] ? abs_rt : abs_rs;
               div0_d   = op[1] && (rt_val == '0);
               // Remainder follows the dividend; product and quotient follow the sign xor.
               neg_hi_d = op[1] ? rs_neg : (rs_neg ^ rt_neg);
               neg_lo_d = rs_neg ^ rt_neg;
            end else if (start && op == OP_MTHI) begin
               hi_d = rs_val;
            end else if (start && op == OP_MTLO) begin
               lo_d = rs_val;
            end
         end
         ST_RUN: begin
            if (is_mul_q) begin
               {acc_d, q_d} = {1'b0, mul_sum, q_q[WIDTH-1:1]};
            end else if (!div_diff[WIDTH]) begin
               acc_d = div_diff;
               q_d   = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = div_shift;
               q_d   = {q_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == '0) state_d = ST_FIX;
            else             cnt_d   = cnt_q - CW'(1);
         end
         ST_FIX: begin
            hi_d    = res_hi;
            lo_d    = div0_q ? DIV0_LO : res_lo;
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_RUN) || (state_d == ST_FIX);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
      acc_q    <= acc_d;
      q_q      <= q_d;
      mag_q    <= mag_d;
      is_mul_q <= is_mul_d;
      div0_q   <= div0_d;
      neg_hi_q <= neg_hi_d;
      neg_lo_q <= neg_lo_d;
   end

   assign busy  = busy_q;
   assign stall = busy_q;
   assign done  = done_q;
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule
